// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction memory fetch handshake
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, imem fetch sequencer and next-PC selection
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_pc_unit_if.master        mem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            link_addr,
  input  logic                   jump,
  input  logic                   beq,
  input  logic                   bne,
  input  logic                   jr,
  input  logic                   alu_zero,
  input  logic [31:0]            rs_data,
  input  logic                   exec_done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int            CW       = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   pc4;
  logic [31:0]   br_offset;
  logic [31:0]   next_pc;
  logic          br_taken;
  logic          jr_bad;

  assign pc4       = pc + 32'd4;
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_taken  = (beq & alu_zero) | (bne & ~alu_zero);
  assign jr_bad    = jr & (rs_data[1:0] != 2'b00);

  always_comb begin
    next_pc = pc4;
    if (jr)
      next_pc = rs_data;
    else if (jump)
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    else if (br_taken)
      next_pc = pc4 + br_offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_FETCH;
    else
      state <= state_nxt;
  end

  // A ready on the final count cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem.imem_ready)
          state_nxt = S_EXEC;
        else if (wait_cnt == CNT_LAST)
          state_nxt = S_ERR;
      end
      S_EXEC: begin
        if (exec_done)
          state_nxt = jr_bad ? S_ERR : S_FETCH;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_comb begin
    mem.imem_req  = (state == S_FETCH);
    instr_valid   = (state == S_EXEC);
    err           = (state == S_ERR);
    mem.imem_addr = pc;
    link_addr     = pc4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      instr    <= 32'd0;
      wait_cnt <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem.imem_ready) begin
            instr    <= mem.imem_rdata;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            err_code <= 2'b01;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            if (jr_bad)
              err_code <= 2'b10;
            else
              pc <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
